// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Circular receive FIFO fed by the UART receiver's data/done
//            outputs, with a registered 1-cycle pop interface.
//            Optional macro RX_FIFO_OVERRUN_FLAG_EN adds a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  tick,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic                  rd_en,
`ifdef RX_FIFO_OVERRUN_FLAG_EN
    input  logic                  overrun_clr,
    output logic                  overrun,
`endif
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_done_q;

    logic                  w_wr_req;
    logic                  w_rd_accept;
    logic                  w_wr_accept;
    logic [ADDR_WIDTH:0]   w_count_next;

    // One write per rising edge of rx_done, however long it stays high.
    assign w_wr_req    = rx_done & ~r_done_q;
    assign w_rd_accept = rd_en & ~r_empty;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign w_wr_accept = w_wr_req & (~r_full | w_rd_accept);

    always_comb begin
        w_count_next = r_count;
        if (w_wr_accept && !w_rd_accept)
            w_count_next = r_count + 1'b1;
        else if (w_rd_accept && !w_wr_accept)
            w_count_next = r_count - 1'b1;
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge tick) begin
        if (w_wr_accept && !reset)
            r_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge tick) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_done_q   <= 1'b1;
        end else begin
            r_done_q   <= rx_done;
            r_rd_valid <= w_rd_accept;
            r_count    <= w_count_next;
            r_empty    <= (w_count_next == '0);
            r_full     <= (w_count_next == c_depth);
            if (w_wr_accept)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_accept) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

`ifdef RX_FIFO_OVERRUN_FLAG_EN
    logic r_overrun;

    // Sticky; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge tick) begin
        if (reset)
            r_overrun <= 1'b0;
        else if (w_wr_req && !w_wr_accept)
            r_overrun <= 1'b1;
        else if (overrun_clr)
            r_overrun <= 1'b0;
    end

    assign overrun = r_overrun;
`endif

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty    = r_empty;
    assign full     = r_full;
    assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed plus randomized bench for uart_rx_fifo against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          tick = 1'b0;
    logic          reset;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic          rd_en;
    logic          overrun_clr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
`ifdef RX_FIFO_OVERRUN_FLAG_EN
    logic          overrun;
`endif

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .tick        (tick),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rd_en       (rd_en),
`ifdef RX_FIFO_OVERRUN_FLAG_EN
        .overrun_clr (overrun_clr),
        .overrun     (overrun),
`endif
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .count       (count)
    );

    always #5 tick = ~tick;

    int errors = 0;
    int checks = 0;

    // Reference model: a plain queue of stored bytes.
    logic [DW-1:0] m_q[$];
    logic          m_done_q  = 1'b1;
    logic [DW-1:0] m_rd_data = '0;
    logic          m_valid   = 1'b0;
    logic          m_ovr     = 1'b0;
    logic [DW-1:0] got[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply current inputs for one tick edge, advance the model, compare.
    task automatic cycle();
        logic wr, rd, was_full;
        wr = rx_done && !m_done_q;
        if (reset) begin
            m_q.delete();
            m_rd_data = '0;
            m_valid   = 1'b0;
            m_done_q  = 1'b1;
            m_ovr     = 1'b0;
        end else begin
            m_done_q = rx_done;
            was_full = (m_q.size() == DEPTH);
            rd       = rd_en && (m_q.size() > 0);
            m_valid  = rd;
            if (rd) m_rd_data = m_q.pop_front();
            if (wr && (!was_full || rd)) m_q.push_back(rx_data);
            if (wr && was_full && !rd) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
        @(posedge tick);
        #1;
        check("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
        check("rd_data", {24'd0, rd_data}, {24'd0, m_rd_data});
        check("count", {27'd0, count}, m_q.size());
        check("empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
        check("full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
`ifdef RX_FIFO_OVERRUN_FLAG_EN
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`endif
        if (rd_valid === 1'b1) got.push_back(rd_data);
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        rx_data = d; rx_done = 1'b1; cycle();
        rx_done = 1'b0; cycle();
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) cycle();
        rd_en = 1'b0;
        cycle();
    endtask

    initial begin
        reset = 1'b1; rx_done = 1'b1; rx_data = 8'h11; rd_en = 1'b0; overrun_clr = 1'b0;

        // Reset with rx_done held high; release must not write.
        repeat (3) cycle();
        reset = 1'b0;
        repeat (3) cycle();
        check("rst_hold_count", {27'd0, count}, 32'd0);
        check("rst_hold_empty", {31'd0, empty}, 32'd1);
        rx_done = 1'b0; cycle();

        // Three bytes in, three pops out in order.
        got.delete();
        pulse(8'h32); pulse(8'hE5); pulse(8'hFF);
        repeat (3) begin
            rd_en = 1'b1; cycle();
            rd_en = 1'b0; cycle();
        end
        check("three_n", got.size(), 32'd3);
        if (got.size() == 3) begin
            check("three_0", {24'd0, got[0]}, 32'h32);
            check("three_1", {24'd0, got[1]}, 32'hE5);
            check("three_2", {24'd0, got[2]}, 32'hFF);
        end
        check("three_empty", {31'd0, empty}, 32'd1);

        // Long done pulse yields a single entry.
        rx_data = 8'h80; rx_done = 1'b1;
        repeat (10) cycle();
        rx_done = 1'b0; cycle();
        check("long_done_count", {27'd0, count}, 32'd1);
        drain(1);

        // Overflow: the 17th byte is dropped.
        for (int i = 0; i < 16; i++) pulse(8'(i));
        pulse(8'hAA);
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_count", {27'd0, count}, 32'd16);
`ifdef RX_FIFO_OVERRUN_FLAG_EN
        check("ovf_flag", {31'd0, overrun}, 32'd1);
        repeat (2) cycle();
        check("ovf_sticky", {31'd0, overrun}, 32'd1);
        overrun_clr = 1'b1; cycle();
        overrun_clr = 1'b0; cycle();
        check("ovf_cleared", {31'd0, overrun}, 32'd0);
`endif
        got.delete();
        drain(16);
        check("ovf_n", got.size(), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check("ovf_data", {24'd0, got[i]}, i);

        // Full FIFO with simultaneous write and read, then drain through the wrap.
        for (int i = 0; i < 16; i++) pulse(8'(8'h10 + i));
        got.delete();
        rx_data = 8'h5A; rx_done = 1'b1; rd_en = 1'b1; cycle();
        rx_done = 1'b0; rd_en = 1'b0; cycle();
        check("both_count", {27'd0, count}, 32'd16);
        check("both_full", {31'd0, full}, 32'd1);
        check("both_oldest", {24'd0, got.size() > 0 ? got[0] : 8'hXX}, 32'h10);
        got.delete();
        drain(16);
        check("wrap_n", got.size(), 32'd16);
        check("wrap_last", {24'd0, got.size() > 0 ? got[got.size()-1] : 8'hXX}, 32'h5A);

        // Pop while empty is ignored.
        rd_en = 1'b1; cycle();
        rd_en = 1'b0;
        check("empty_pop_valid", {31'd0, rd_valid}, 32'd0);
        check("empty_pop_data", {24'd0, rd_data}, 32'h5A);
        cycle();

        // Reset with entries stored.
        for (int i = 0; i < 5; i++) pulse(8'(8'hC0 + i));
        check("pre_rst_count", {27'd0, count}, 32'd5);
        reset = 1'b1; cycle();
        check("mid_rst_count", {27'd0, count}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
        reset = 1'b0; cycle();

        // Randomized traffic; write-heavy and read-heavy phases exercise both ends.
        for (int n = 0; n < 3000; n++) begin
            int wr_pct;
            wr_pct      = ((n / 500) % 2 == 0) ? 70 : 25;
            rx_data     = 8'($urandom);
            rx_done     = ($urandom_range(99) < wr_pct);
            rd_en       = ($urandom_range(99) < 100 - wr_pct);
            overrun_clr = ($urandom_range(99) < 5);
            reset       = ($urandom_range(999) < 3);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
